riscv_wb_arbiter: RTL
=====================

Name: riscv_wb_arbiter

Overview:
Shares the single write port of the RISC-V register file among NUM_SRC writeback sources. Default sources are ALU (0), LSU (1) and MULDIV (2). Each source presents a valid/ready request with its rd index and data. The block picks one winner per cycle using round-robin priority and registers the winner onto the register-file write port (we_i / write_register_i / write_data_i). It sits between the execute/memory units and the register file.

Parameters:
NUM_SRC, 3, number of writeback requesters (2..8)
XLEN, 64, register data width
SRC_W, $clog2(NUM_SRC), width of source index (localparam-derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
req_valid_i  input  NUM_SRC  bit s: source s has a writeback pending
req_rd_i  input  5*NUM_SRC  rd index of source s in bits [5s+4:5s]
req_data_i  input  XLEN*NUM_SRC  write data of source s in bits [XLEN*s+XLEN-1:XLEN*s]
req_ready_o  output  NUM_SRC  one-hot grant, combinational; transfer when valid&ready
rf_we_o  output  1  register file write enable (to we_i), registered
rf_rd_o  output  5  destination index (to write_register_i), registered
rf_wdata_o  output  XLEN  write data (to write_data_i), registered
rf_src_o  output  SRC_W  index of source that produced current rf_* write, registered
conflict_o  output  1  registered; 1 if the previous cycle had more than one valid request

Behaviour:
- Reset (rst=1 at rising edge): rr_ptr=0, rf_we_o=0, rf_rd_o=0, rf_wdata_o=0, rf_src_o=0, conflict_o=0. While rst=1, req_ready_o=0.
- Arbitration (combinational):
  - Search order is rr_ptr, rr_ptr+1, ... wrapping mod NUM_SRC.
  - The first s with req_valid_i[s]=1 gets req_ready_o[s]=1; all other ready bits are 0.
  - No valid requests gives req_ready_o=0.
  - req_ready_o is at most one-hot.
- Pointer update: on a transfer from source g, rr_ptr <= (g+1) mod NUM_SRC. With no transfer, rr_ptr holds. The wrap at NUM_SRC-1 returns to 0, including non-power-of-2 NUM_SRC.
- Write stage: the register file never stalls, so every granted request is accepted in its cycle. At the next edge:
  - rf_rd_o <= rd_g, rf_wdata_o <= data_g, rf_src_o <= g.
  - rf_we_o <= (rd_g != 0).
- Latency: a request granted in cycle N appears on the rf_* write port in cycle N+1. The register file commits it at the end of cycle N+1.
- x0 writes: the request is granted and consumed normally (ready=1, pointer advances), but rf_we_o=0. rf_rd_o/rf_wdata_o/rf_src_o still update and are don't-care for the register file.
- No transfer in a cycle: rf_we_o <= 0. rf_rd_o, rf_wdata_o and rf_src_o hold their previous values.
- Requester protocol: once req_valid_i[s]=1, the source holds valid, rd and data stable until req_ready_o[s]=1. The block does not check this. A losing request stays pending and is served within NUM_SRC cycles (starvation bound).
- Same rd from two sources: the two writes commit in grant order, and the later-granted write wins in the register file. Ordering between sources is the issuer's responsibility.
- conflict_o <= (popcount(req_valid_i) > 1) every non-reset cycle.
- Reset mid-operation: pending requests are not granted during reset. An rf write already registered before the reset edge is cleared (rf_we_o=0 after the reset edge). After reset deasserts, arbitration restarts from source 0.

Test Plan:
- Single request: reset, then valid[1]=1, rd=5, data=0xDEAD_BEEF for one cycle. Required: ready[1]=1 that cycle; next cycle rf_we_o=1, rf_rd_o=5, rf_wdata_o=0xDEADBEEF, rf_src_o=1; the cycle after, rf_we_o=0.
- Round-robin: after reset, all 3 sources held valid (rd 1/2/3). Required: grants in cycles 0,1,2,3 are src 0,1,2,0. rf_rd_o sequence is 1,2,3,1 one cycle later. conflict_o=1 from cycle 1.
- Pointer skip/wrap: rr_ptr=2 (after a grant to src 1), only src 0 valid. Required: src 0 granted immediately, then rr_ptr=1.
- x0 drop: valid[2]=1, rd=0, data=0x1234. Required: ready[2]=1, next cycle rf_we_o=0, rf_src_o=2, pointer advances to 0.
- Same-rd ordering: src 0 and src 2 both valid with rd=7, data A=0x11 and B=0x22, rr_ptr=0. Required: rf writes 0x11 then 0x22 on consecutive cycles; a register-file read of x7 afterwards returns 0x22.
- Reset mid-operation: with all sources valid and rf_we_o=1, assert rst for 2 cycles. Required: req_ready_o=0 and rf_we_o=0 after the first reset edge. After release, the first grant goes to src 0.

Source files
------------

// File: rtl/riscv_wb_arbiter.sv
// Round-robin writeback arbiter for the single register-file write port.
// One requester wins per cycle. The winner is registered onto the rf_* port
// one cycle later. Writes to x0 are consumed, but their write enable is suppressed.
module riscv_wb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = 64,
  localparam int SRC_W  = $clog2(NUM_SRC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC-1:0]      req_valid_i,
  input  logic [5*NUM_SRC-1:0]    req_rd_i,
  input  logic [XLEN*NUM_SRC-1:0] req_data_i,
  output logic [NUM_SRC-1:0]      req_ready_o,
  output logic                    rf_we_o,
  output logic [4:0]              rf_rd_o,
  output logic [XLEN-1:0]         rf_wdata_o,
  output logic [SRC_W-1:0]        rf_src_o,
  output logic                    conflict_o
);

  logic [SRC_W-1:0]   rr_ptr;
  logic [NUM_SRC-1:0] grant;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   cand;
  logic               found;
  logic               xfer;
  logic [4:0]         sel_rd;
  logic [XLEN-1:0]    sel_data;
  logic [SRC_W-1:0]   next_ptr;

  // Scan the sources starting at rr_ptr, wrapping mod NUM_SRC, and grant the first valid one.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = SRC_W'((int'(rr_ptr) + i) % NUM_SRC);
      if (!found && req_valid_i[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

  // Mask grants during reset and select the winner's rd, data and next pointer.
  always_comb begin
    req_ready_o = rst ? '0 : grant;
    xfer        = found && !rst;
    sel_rd      = req_rd_i[int'(grant_idx)*5 +: 5];
    sel_data    = req_data_i[int'(grant_idx)*XLEN +: XLEN];
    next_ptr    = (grant_idx == SRC_W'(NUM_SRC-1)) ? '0 : grant_idx + 1'b1;
  end

  // Register the winning request onto the write port and advance the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      rf_we_o    <= 1'b0;
      rf_rd_o    <= '0;
      rf_wdata_o <= '0;
      rf_src_o   <= '0;
      conflict_o <= 1'b0;
    end else begin
      conflict_o <= ($countones(req_valid_i) > 1);
      if (xfer) begin
        rr_ptr     <= next_ptr;
        rf_we_o    <= (sel_rd != 5'd0);
        rf_rd_o    <= sel_rd;
        rf_wdata_o <= sel_data;
        rf_src_o   <= grant_idx;
      end else begin
        rf_we_o <= 1'b0;
      end
    end
  end

endmodule
